// File: rtl/mem_lsu.sv
// mem_lsu: big-endian load/store initiator between the memory stage and the 4K data memory.
// Ports: clk, rst (sync, active-high); req_valid/req_ready handshake with req_we, req_size,
// req_signed, req_addr, req_wdata; resp_valid strobe with resp_rdata, resp_err;
// data memory port dm_addr, dm_din, dm_bext, dm_wen out and dm_dout in.
// Macro LSU_HALFWORD_EN enables halfword loads/stores; without it size 01 is rejected as an error.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_din,
  output logic [1:0]  dm_bext,
  output logic [1:0]  dm_wen,
  input  logic [31:0] dm_dout
);
  typedef enum logic [1:0] {IDLE, MEM0, MEM1, RESP} state_t;
  state_t state_q;
  logic we_q, sgn_q, err_q, req_err, mem_st;
  logic [1:0] size_q;
  logic [11:0] addr_q, dm_addr_q;
  logic [31:0] dm_din_q, rdata_q, rdata_d, shifted;
  logic [15:0] half_sel;
`ifdef LSU_HALFWORD_EN
  logic [7:0] lo_q;
`endif
  always_comb begin
`ifdef LSU_HALFWORD_EN
    req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b00 && req_addr[1:0] != 2'b00);
`else
    req_err = req_size[0] || (req_size == 2'b00 && req_addr[1:0] != 2'b00);
`endif
    // big-endian: byte offset 0 is the most significant byte of the word
    shifted = dm_dout >> {~addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? dm_dout[15:0] : dm_dout[31:16];
    rdata_d = size_q == 2'b10 ? {{24{sgn_q & shifted[7]}}, shifted[7:0]} :
              size_q == 2'b01 ? {{16{sgn_q & half_sel[15]}}, half_sel} : dm_dout;
    mem_st = we_q && (state_q == MEM0 || state_q == MEM1);
  end
  assign req_ready  = !rst && state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dm_addr    = dm_addr_q;
  assign dm_din     = dm_din_q;
  // reset masks the write strobe so an interrupted store never commits on the reset edge
  assign dm_wen     = (mem_st && !rst) ? 2'b01 : 2'b00;
  assign dm_bext    = (mem_st && size_q != 2'b00) ? 2'b10 : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      dm_addr_q <= '0;
      dm_din_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q   <= req_we;
          size_q <= req_size;
          sgn_q  <= req_signed;
          addr_q <= req_addr;
`ifdef LSU_HALFWORD_EN
          lo_q   <= req_wdata[7:0];
`endif
          if (req_err) begin
            state_q <= RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            state_q   <= MEM0;
            // loads and word stores use the word address; byte/half stores the byte address
            dm_addr_q <= (req_we && req_size != 2'b00) ? req_addr : {req_addr[11:2], 2'b00};
            if (req_we)
              dm_din_q <= req_size == 2'b00 ? req_wdata :
                          {24'b0, req_size == 2'b10 ? req_wdata[7:0] : req_wdata[15:8]};
          end
        end
        MEM0: begin
`ifdef LSU_HALFWORD_EN
          if (we_q && size_q == 2'b01) begin
            state_q   <= MEM1;
            dm_addr_q <= {addr_q[11:1], 1'b1};
            dm_din_q  <= {24'b0, lo_q};
          end else
`endif
          begin
            state_q <= RESP;
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : rdata_d;
          end
        end
`ifdef LSU_HALFWORD_EN
        MEM1: begin
          state_q <= RESP;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
`endif
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a big-endian byte-writable memory model.
module tb_mem_lsu;
`ifdef LSU_HALFWORD_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, dm_din, dm_dout;
  logic [11:0] dm_addr;
  logic [1:0] dm_bext, dm_wen;
  logic [31:0] mem [0:1023];
  logic pl_en = 1'b0;
  logic [9:0] pl_idx = '0;
  logic [31:0] pl_data = '0;
  int wr_cnt = 0;
  logic [23:0] wr_hist = '0;
  logic [1:0] last_bext = 2'b11;
  int errors = 0, checks = 0;
  int lat, nw, w0;
  logic [31:0] rd;
  logic er;

  mem_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_addr(dm_addr),
    .dm_din(dm_din), .dm_bext(dm_bext), .dm_wen(dm_wen), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;
  assign dm_dout = mem[dm_addr[11:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (dm_wen == 2'b01) begin
      if (dm_bext == 2'b10) mem[dm_addr[11:2]][{~dm_addr[1:0], 3'b000} +: 8] <= dm_din[7:0];
      else mem[dm_addr[11:2]] <= dm_din;
      wr_cnt <= wr_cnt + 1;
      wr_hist <= {wr_hist[11:0], dm_addr};
      last_bext <= dm_bext;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic sgn, input logic [11:0] addr,
                     input logic [31:0] wd, output int l, output logic [31:0] r, output logic e, output int n);
    int w, t;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 8) begin @(negedge clk); t++; end
    w = wr_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    l = 1;
    while (!resp_valid && l < 8) begin @(negedge clk); l++; end
    r = resp_rdata; e = resp_err; n = wr_cnt - w;
  endtask

  initial begin
    preload(10'h010, 32'h8A3C_F012);
    preload(10'h011, 32'h1122_3344);
    preload(10'h040, 32'h0);
    preload(10'h080, 32'h0);
    @(negedge clk);
    pl_en = 1'b0;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_wen", {30'b0, dm_wen}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_addr", {20'b0, dm_addr}, 32'd0);
    chk("rst_din", dm_din, 32'd0);
    chk("rst_bext", {30'b0, dm_bext}, 32'd0);

    txn(1'b0, 2'b10, 1'b1, 12'h040, 32'h0, lat, rd, er, nw);
    chk("lb_s_040_data", rd, 32'hFFFF_FF8A);
    chk("lb_s_040_lat", lat, 32'd2);
    chk("lb_s_040_err", {31'b0, er}, 32'd0);
    txn(1'b0, 2'b10, 1'b0, 12'h041, 32'h0, lat, rd, er, nw);
    chk("lb_u_041_data", rd, 32'h0000_003C);
    txn(1'b0, 2'b10, 1'b1, 12'h042, 32'h0, lat, rd, er, nw);
    chk("lb_s_042_data", rd, 32'hFFFF_FFF0);
    txn(1'b0, 2'b10, 1'b0, 12'h043, 32'h0, lat, rd, er, nw);
    chk("lb_u_043_data", rd, 32'h0000_0012);

    txn(1'b0, 2'b01, 1'b0, 12'h042, 32'h0, lat, rd, er, nw);
    chk("lh_u_042_data", rd, HW ? 32'h0000_F012 : 32'h0);
    chk("lh_u_042_err", {31'b0, er}, HW ? 32'd0 : 32'd1);
    chk("lh_u_042_lat", lat, HW ? 32'd2 : 32'd1);
    txn(1'b0, 2'b01, 1'b1, 12'h042, 32'h0, lat, rd, er, nw);
    chk("lh_s_042_data", rd, HW ? 32'hFFFF_F012 : 32'h0);

    txn(1'b1, 2'b01, 1'b0, 12'h046, 32'h0000_BEEF, lat, rd, er, nw);
    chk("sh_046_lat", lat, HW ? 32'd3 : 32'd1);
    chk("sh_046_writes", nw, HW ? 32'd2 : 32'd0);
    chk("sh_046_addrs", {8'b0, wr_hist}, HW ? 32'h0004_6047 : 32'h0);
    chk("sh_046_err", {31'b0, er}, HW ? 32'd0 : 32'd1);
    chk("sh_046_rdata", rd, 32'd0);
    txn(1'b0, 2'b00, 1'b0, 12'h044, 32'h0, lat, rd, er, nw);
    chk("lw_044_after_sh", rd, HW ? 32'h1122_BEEF : 32'h1122_3344);

    txn(1'b1, 2'b10, 1'b0, 12'h045, 32'hFFFF_FF5A, lat, rd, er, nw);
    chk("sb_045_lat", lat, 32'd2);
    chk("sb_045_writes", nw, 32'd1);
    chk("sb_045_addr", {20'b0, wr_hist[11:0]}, 32'h0000_0045);
    chk("sb_045_bext", {30'b0, last_bext}, 32'd2);
    txn(1'b0, 2'b00, 1'b0, 12'h044, 32'h0, lat, rd, er, nw);
    chk("lw_044_after_sb", rd, HW ? 32'h115A_BEEF : 32'h115A_3344);
    txn(1'b0, 2'b10, 1'b1, 12'h045, 32'h0, lat, rd, er, nw);
    chk("lb_s_045_data", rd, 32'h0000_005A);

    txn(1'b0, 2'b00, 1'b0, 12'h041, 32'h0, lat, rd, er, nw);
    chk("lw_041_err", {31'b0, er}, 32'd1);
    chk("lw_041_rdata", rd, 32'd0);
    chk("lw_041_writes", nw, 32'd0);
    chk("lw_041_lat", lat, 32'd1);
    txn(1'b1, 2'b01, 1'b0, 12'h043, 32'h1234, lat, rd, er, nw);
    chk("sh_043_err", {31'b0, er}, 32'd1);
    chk("sh_043_writes", nw, 32'd0);
    txn(1'b1, 2'b11, 1'b0, 12'h040, 32'h1234, lat, rd, er, nw);
    chk("rsv_size_err", {31'b0, er}, 32'd1);
    chk("rsv_size_lat", lat, 32'd1);

    @(negedge clk);
    w0 = wr_cnt;
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 12'h100; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(negedge clk);
    chk("b2b_busy_mem0", {31'b0, req_ready}, 32'd0);
    req_we = 1'b0; req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("b2b_resp1_valid", {31'b0, resp_valid}, 32'd1);
    chk("b2b_resp1_rdata", resp_rdata, 32'd0);
    chk("b2b_busy_resp", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready_idle", {31'b0, req_ready}, 32'd1);
    chk("b2b_sw_writes", wr_cnt - w0, 32'd1);
    chk("b2b_sw_bext", {30'b0, last_bext}, 32'd0);
    @(negedge clk);
    chk("b2b_mem0_novalid", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_resp2_valid", {31'b0, resp_valid}, 32'd1);
    chk("b2b_resp2_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("b2b_resp2_err", {31'b0, resp_err}, 32'd0);

    @(negedge clk);
    w0 = wr_cnt;
    req_we = 1'b1; req_size = 2'b00; req_addr = 12'h200; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_wen_before", {30'b0, dm_wen}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_wen_forced", {30'b0, dm_wen}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_no_write", wr_cnt - w0, 32'd0);
    chk("rstmid_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("rstmid_mem", mem[10'h080], 32'd0);
    @(negedge clk);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_no_resp2", {31'b0, resp_valid}, 32'd0);
    txn(1'b0, 2'b00, 1'b0, 12'h200, 32'h0, lat, rd, er, nw);
    chk("rstmid_lw_200", rd, 32'd0);
    chk("rstmid_lw_lat", lat, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
